ins_encoder: RTL

- Streaming RISC-V RV32I instruction encoder. It is the inverse of the core's immediate/field decode.
- Accepts an instruction format code, register fields, funct fields, opcode and a 32-bit immediate. Packs them into a 32-bit instruction word.
- Range-checks the immediate and tags each word with a sequential instruction-memory byte address.
- Sits between the boot loader / test sequencer and the instruction-memory write port. Valid/ready on both sides, 2-stage pipeline.

---
 rtl/rv32_pkg.sv | 48 ++++
 rtl/ins_pack.sv | 56 +++++
 rtl/ins_encoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// RV32I encoding constants shared by the encoder, its packer and test sequencers.
// Format codes, major opcodes, immediate range limits and the field bundle carried through S1.
package rv32_pkg;

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_ISH = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_R   = 3'd6;
    localparam logic [2:0] FMT_INV = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MIN = 0;
    localparam int SHAMT_MAX = 31;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } ins_fields_t;

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/ins_pack.sv
// Combinational RV32I packer and immediate range checker; zero latency, no flow control.
// Out-of-range immediates are still packed (truncated); the invalid format packs to zero.
module ins_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] ins,
    output logic        err
);

    always_comb begin
        ins = '0;
        err = 1'b0;
        case (fmt)
            FMT_I: begin
                ins = {imm[11:0], rs1, funct3, rd, opcode};
                err = !in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_ISH: begin
                ins = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                err = !in_range(imm, SHAMT_MIN, SHAMT_MAX);
            end
            FMT_S: begin
                ins = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err = !in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                ins = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err = !in_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
            end
            FMT_U: begin
                ins = {imm[31:12], rd, opcode};
                err = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                ins = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err = !in_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
            end
            FMT_R: begin
                ins = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            default: begin
                ins = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ins_encoder.sv
// Streaming RV32I encoder: fields in, packed word + imem byte address + error flag out; 2-cycle latency.
// Valid/ready both sides; bubbles collapse, InReady drops only with both stages full and OutReady low.
module ins_encoder
    import rv32_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERRCNT_W  = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Clear,
    input  logic                InValid,
    output logic                InReady,
    input  logic [2:0]          Fmt,
    input  logic [6:0]          Opcode,
    input  logic [4:0]          Rd,
    input  logic [4:0]          Rs1,
    input  logic [4:0]          Rs2,
    input  logic [2:0]          Funct3,
    input  logic [6:0]          Funct7,
    input  logic [31:0]         Imm,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [31:0]         OutIns,
    output logic [ADDR_W-1:0]   OutAddr,
    output logic                OutErr,
    output logic [ERRCNT_W-1:0] ErrCount
);

    logic                rdy_en_q, rdy_en_d;
    logic                s1_vld_q, s1_vld_d;
    ins_fields_t         s1_q, s1_d;
    logic                s2_vld_q, s2_vld_d;
    logic [31:0]         s2_ins_q, s2_ins_d;
    logic                s2_err_q, s2_err_d;
    logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                in_fire, out_fire, s2_load;
    logic [ADDR_W-1:0]   load_addr;
    logic [31:0]         pack_ins;
    logic                pack_err;

    ins_pack u_pack (
        .fmt    (s1_q.fmt),
        .opcode (s1_q.opcode),
        .rd     (s1_q.rd),
        .rs1    (s1_q.rs1),
        .rs2    (s1_q.rs2),
        .funct3 (s1_q.funct3),
        .funct7 (s1_q.funct7),
        .imm    (s1_q.imm),
        .ins    (pack_ins),
        .err    (pack_err)
    );

    // rdy_en_q keeps InReady low while in reset and for the cycle of release.
    assign InReady  = rdy_en_q && (!s1_vld_q || !s2_vld_q || OutReady);
    assign in_fire  = InValid && InReady;
    assign out_fire = s2_vld_q && OutReady;
    assign s2_load  = s1_vld_q && (!s2_vld_q || OutReady);

    // The address counter names the next word entering S2, so Clear always lands on the following word.
    assign load_addr = Clear ? BASE_ADDR : next_addr_q;

    always_comb begin
        rdy_en_d    = 1'b1;
        s1_vld_d    = s1_vld_q;
        s1_d        = s1_q;
        s2_vld_d    = s2_vld_q;
        s2_ins_d    = s2_ins_q;
        s2_err_d    = s2_err_q;
        s2_addr_d   = s2_addr_q;
        next_addr_d = load_addr;
        err_cnt_d   = err_cnt_q;

        if (out_fire) s2_vld_d = 1'b0;
        if (s2_load) begin
            s2_vld_d    = 1'b1;
            s2_ins_d    = pack_ins;
            s2_err_d    = pack_err;
            s2_addr_d   = load_addr;
            next_addr_d = load_addr + ADDR_W'(4);
            s1_vld_d    = 1'b0;
        end
        if (in_fire) begin
            s1_vld_d = 1'b1;
            s1_d     = '{fmt: Fmt, opcode: Opcode, rd: Rd, rs1: Rs1, rs2: Rs2,
                         funct3: Funct3, funct7: Funct7, imm: Imm};
        end

        if (Clear) begin
            err_cnt_d = '0;
        end else if (out_fire && s2_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdy_en_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_q        <= '0;
            s2_vld_q    <= 1'b0;
            s2_ins_q    <= '0;
            s2_err_q    <= 1'b0;
            s2_addr_q   <= BASE_ADDR;
            next_addr_q <= BASE_ADDR;
            err_cnt_q   <= '0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            s1_vld_q    <= s1_vld_d;
            s1_q        <= s1_d;
            s2_vld_q    <= s2_vld_d;
            s2_ins_q    <= s2_ins_d;
            s2_err_q    <= s2_err_d;
            s2_addr_q   <= s2_addr_d;
            next_addr_q <= next_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign OutValid = s2_vld_q;
    assign OutIns   = s2_ins_q;
    assign OutAddr  = s2_addr_q;
    assign OutErr   = s2_err_q;
    assign ErrCount = err_cnt_q;

endmodule
